// File: rtl/inst_ram_loader_pkg.sv
// Shared types and constants for the instruction RAM loader.
package inst_ram_loader_pkg;

    localparam int unsigned IRL_ADDR_W = 5;
    localparam int unsigned IRL_DEPTH  = 32;
    localparam int unsigned IRL_CNT_W  = 6;

    // An all-zero word executes as a nop on the CPU.
    localparam logic [31:0] IRL_NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_DATA,
        ST_CHECK
    } load_state_t;

endpackage

// File: rtl/inst_ram_dp.sv
// Instruction RAM: synchronous write, synchronous clear, asynchronous read.
module inst_ram_dp
    import inst_ram_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = IRL_ADDR_W,
    parameter int unsigned DEPTH  = IRL_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];

    // Clear every word to nop on reset, otherwise write one word per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= IRL_NOP_WORD;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Combinational read; a word written on an edge is visible after that edge.
    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_ram_loader.sv
// Byte-stream loader that fills the CPU instruction RAM and holds the CPU
// while a load is running or after a failed load.
module inst_ram_loader
    import inst_ram_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = IRL_ADDR_W,
    parameter int unsigned DEPTH  = IRL_DEPTH,
    parameter int unsigned CNT_W  = IRL_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] addr,
    output logic [31:0]       inst,
    output logic              busy,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [CNT_W-1:0]  words_loaded
);

    load_state_t      state;
    logic [CNT_W-1:0] word_count;
    logic [1:0]       byte_idx;
    logic [23:0]      word_sr;
    logic [7:0]       checksum;

    logic             accept;
    logic             ram_we;
    logic [31:0]      ram_wdata;
    logic [CNT_W-1:0] words_next;

    assign accept     = in_valid & in_ready;
    assign ram_we     = accept && (state == ST_DATA) && (byte_idx == 2'd3);
    assign ram_wdata  = {word_sr, in_byte};
    assign words_next = words_loaded + CNT_W'(1);
    assign cpu_hold   = busy | load_err;

    // Load session FSM; in_ready and busy are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            in_ready     <= 1'b0;
            busy         <= 1'b0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
            word_count   <= '0;
            byte_idx     <= '0;
            word_sr      <= '0;
            checksum     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load_start) begin
                        state        <= ST_COUNT;
                        in_ready     <= 1'b1;
                        busy         <= 1'b1;
                        load_done    <= 1'b0;
                        load_err     <= 1'b0;
                        words_loaded <= '0;
                        byte_idx     <= '0;
                        word_sr      <= '0;
                        checksum     <= '0;
                    end
                end
                ST_COUNT: begin
                    if (accept) begin
                        if ((in_byte == 8'd0) || (in_byte > 8'(DEPTH))) begin
                            load_err <= 1'b1;
                            state    <= ST_IDLE;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                        end else begin
                            word_count <= in_byte[CNT_W-1:0];
                            state      <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        word_sr  <= {word_sr[15:0], in_byte};
                        checksum <= checksum ^ in_byte;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            words_loaded <= words_next;
                            if (words_next == word_count) begin
                                state <= ST_CHECK;
                            end
                        end
                    end
                end
                ST_CHECK: begin
                    if (accept) begin
                        if (in_byte == checksum) begin
                            load_done <= 1'b1;
                        end else begin
                            load_err <= 1'b1;
                        end
                        state    <= ST_IDLE;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    inst_ram_dp #(
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk  (clk),
        .rst  (rst),
        .we   (ram_we),
        .waddr(words_loaded[ADDR_W-1:0]),
        .wdata(ram_wdata),
        .raddr(addr),
        .rdata(inst)
    );

endmodule

// File: tb/tb_inst_ram_loader.sv
// Scoreboard bench for inst_ram_loader: expected RAM words are queued as the
// stream is driven and compared against the inst read port after each load.
module tb_inst_ram_loader;

    logic        clk;
    logic        rst;
    logic        load_start;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic [4:0]  addr;
    logic [31:0] inst;
    logic        busy;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;
    logic [5:0]  words_loaded;

    int          n_pass;
    int          n_total;
    int          acc_cnt;

    logic [31:0] mem_model [32];
    logic [31:0] tx_words  [32];
    int          sb_addr [$];
    logic [31:0] sb_word [$];

    inst_ram_loader dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .in_valid    (in_valid),
        .in_byte     (in_byte),
        .in_ready    (in_ready),
        .addr        (addr),
        .inst        (inst),
        .busy        (busy),
        .cpu_hold    (cpu_hold),
        .load_done   (load_done),
        .load_err    (load_err),
        .words_loaded(words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every byte the DUT actually takes.
    always @(posedge clk) begin
        if (in_valid === 1'b1 && in_ready === 1'b1) acc_cnt++;
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) mem_model[i] = 32'h0;
        sb_addr.delete();
        sb_word.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        load_start = 1'b1;
        @(posedge clk);
        #1;
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_byte  = b;
        while (in_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (in_ready !== 1'b1) begin
            n_total++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waited);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic load_stream(input logic [7:0] cnt, input int nwords,
                               input logic [7:0] csum, input int gap);
        logic [31:0] w;
        pulse_start();
        send_byte(cnt, gap);
        if (cnt != 8'd0 && cnt <= 8'd32) begin
            for (int i = 0; i < nwords; i++) begin
                w = tx_words[i];
                send_byte(w[31:24], gap);
                send_byte(w[23:16], gap);
                send_byte(w[15:8],  gap);
                send_byte(w[7:0],   gap);
                mem_model[i] = w;
                sb_addr.push_back(i);
                sb_word.push_back(w);
            end
            send_byte(csum, gap);
        end
    endtask

    task automatic test_reset();
        int errs;
        apply_reset();
        n_total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b required 0", in_ready); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b required 0", busy); else n_pass++;
        n_total++; if (load_done !== 1'b0 || load_err !== 1'b0) $display("FAIL rst_status: got done=%b err=%b required 0/0", load_done, load_err); else n_pass++;
        n_total++; if (words_loaded !== 6'd0) $display("FAIL rst_words: got %0d required 0", words_loaded); else n_pass++;
        n_total++; if (cpu_hold !== 1'b0) $display("FAIL rst_hold: got %b required 0", cpu_hold); else n_pass++;
        errs = 0;
        for (int i = 0; i < 32; i++) begin
            addr = 5'(i);
            #1;
            if (inst !== 32'h0) errs++;
        end
        n_total++; if (errs != 0) $display("FAIL rst_ram: got %0d nonzero words required 0", errs); else n_pass++;
    endtask

    task automatic test_good_load();
        int a0;
        int a;
        logic [31:0] w;
        tx_words[0] = 32'h2402_0001;
        tx_words[1] = 32'h2403_0001;
        a0 = acc_cnt;
        load_stream(8'h02, 2, 8'h01, 0);
        n_total++; if (load_done !== 1'b1 || load_err !== 1'b0) $display("FAIL good_status: got done=%b err=%b required 1/0", load_done, load_err); else n_pass++;
        n_total++; if (words_loaded !== 6'd2) $display("FAIL good_words: got %0d required 2", words_loaded); else n_pass++;
        n_total++; if (cpu_hold !== 1'b0 || busy !== 1'b0) $display("FAIL good_hold: got hold=%b busy=%b required 0/0", cpu_hold, busy); else n_pass++;
        n_total++; if (acc_cnt - a0 != 10) $display("FAIL good_accepted: got %0d bytes required 10", acc_cnt - a0); else n_pass++;
        while (sb_addr.size() > 0) begin
            a = sb_addr.pop_front();
            w = sb_word.pop_front();
            addr = 5'(a);
            #1;
            n_total++; if (inst !== w) $display("FAIL good_ram[%0d]: got %h required %h", a, inst, w); else n_pass++;
        end
        addr = 5'd2;
        #1;
        n_total++; if (inst !== 32'h0) $display("FAIL good_ram2: got %h required 00000000", inst); else n_pass++;
    endtask

    task automatic test_backpressure();
        int a0;
        int a;
        logic [31:0] w;
        apply_reset();
        a0 = acc_cnt;
        @(negedge clk);
        in_valid = 1'b1;
        in_byte  = 8'hAA;
        repeat (4) @(negedge clk);
        n_total++; if (acc_cnt != a0) $display("FAIL bp_idle_accept: got %0d bytes required 0", acc_cnt - a0); else n_pass++;
        n_total++; if (in_ready !== 1'b0 || busy !== 1'b0) $display("FAIL bp_idle_ready: got ready=%b busy=%b required 0/0", in_ready, busy); else n_pass++;
        in_valid = 1'b0;
        tx_words[0] = 32'h2402_0001;
        tx_words[1] = 32'h2403_0001;
        load_stream(8'h02, 2, 8'h01, 3);
        n_total++; if (load_done !== 1'b1 || load_err !== 1'b0) $display("FAIL bp_status: got done=%b err=%b required 1/0", load_done, load_err); else n_pass++;
        n_total++; if (words_loaded !== 6'd2) $display("FAIL bp_words: got %0d required 2", words_loaded); else n_pass++;
        n_total++; if (acc_cnt - a0 != 10) $display("FAIL bp_accepted: got %0d bytes required 10", acc_cnt - a0); else n_pass++;
        while (sb_addr.size() > 0) begin
            a = sb_addr.pop_front();
            w = sb_word.pop_front();
            addr = 5'(a);
            #1;
            n_total++; if (inst !== w) $display("FAIL bp_ram[%0d]: got %h required %h", a, inst, w); else n_pass++;
        end
    endtask

    task automatic test_bad_count();
        logic [7:0] cnts [2];
        int errs;
        cnts[0] = 8'h00;
        cnts[1] = 8'h21;
        for (int k = 0; k < 2; k++) begin
            load_stream(cnts[k], 0, 8'h00, 0);
            n_total++; if (load_err !== 1'b1 || load_done !== 1'b0) $display("FAIL badcnt_status[%0d]: got done=%b err=%b required 0/1", k, load_done, load_err); else n_pass++;
            n_total++; if (in_ready !== 1'b0 || busy !== 1'b0) $display("FAIL badcnt_idle[%0d]: got ready=%b busy=%b required 0/0", k, in_ready, busy); else n_pass++;
            n_total++; if (cpu_hold !== 1'b1) $display("FAIL badcnt_hold[%0d]: got %b required 1", k, cpu_hold); else n_pass++;
            errs = 0;
            for (int i = 0; i < 32; i++) begin
                addr = 5'(i);
                #1;
                if (inst !== mem_model[i]) errs++;
            end
            n_total++; if (errs != 0) $display("FAIL badcnt_ram[%0d]: got %0d changed words required 0", k, errs); else n_pass++;
        end
    endtask

    task automatic test_bad_checksum();
        int a;
        logic [31:0] w;
        tx_words[0] = 32'h8C01_0004;
        tx_words[1] = 32'hAC02_0008;
        load_stream(8'h02, 2, 8'h00, 0);
        n_total++; if (load_err !== 1'b1 || load_done !== 1'b0) $display("FAIL badsum_status: got done=%b err=%b required 0/1", load_done, load_err); else n_pass++;
        n_total++; if (cpu_hold !== 1'b1) $display("FAIL badsum_hold: got %b required 1", cpu_hold); else n_pass++;
        n_total++; if (words_loaded !== 6'd2) $display("FAIL badsum_words: got %0d required 2", words_loaded); else n_pass++;
        while (sb_addr.size() > 0) begin
            a = sb_addr.pop_front();
            w = sb_word.pop_front();
            addr = 5'(a);
            #1;
            n_total++; if (inst !== w) $display("FAIL badsum_ram[%0d]: got %h required %h", a, inst, w); else n_pass++;
        end
        tx_words[0] = 32'h2402_0001;
        tx_words[1] = 32'h2403_0001;
        load_stream(8'h02, 2, 8'h01, 0);
        sb_addr.delete();
        sb_word.delete();
        n_total++; if (load_err !== 1'b0 || load_done !== 1'b1) $display("FAIL recover_status: got done=%b err=%b required 1/0", load_done, load_err); else n_pass++;
        n_total++; if (cpu_hold !== 1'b0) $display("FAIL recover_hold: got %b required 0", cpu_hold); else n_pass++;
    endtask

    task automatic test_full_depth();
        int a;
        logic [31:0] w;
        for (int i = 0; i < 32; i++) tx_words[i] = 32'(i);
        // XOR of 0..31 is 0.
        load_stream(8'h20, 32, 8'h00, 0);
        n_total++; if (words_loaded !== 6'd32) $display("FAIL full_words: got %0d required 32", words_loaded); else n_pass++;
        n_total++; if (load_done !== 1'b1 || load_err !== 1'b0) $display("FAIL full_status: got done=%b err=%b required 1/0", load_done, load_err); else n_pass++;
        while (sb_addr.size() > 0) begin
            a = sb_addr.pop_front();
            w = sb_word.pop_front();
            addr = 5'(a);
            #1;
            n_total++; if (inst !== w) $display("FAIL full_ram[%0d]: got %h required %h", a, inst, w); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_load();
        int errs;
        int a0;
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h24, 0);
        send_byte(8'h02, 0);
        apply_reset();
        n_total++; if (busy !== 1'b0 || in_ready !== 1'b0 || cpu_hold !== 1'b0) $display("FAIL midrst_ctrl: got busy=%b ready=%b hold=%b required 0/0/0", busy, in_ready, cpu_hold); else n_pass++;
        n_total++; if (load_done !== 1'b0 || load_err !== 1'b0 || words_loaded !== 6'd0) $display("FAIL midrst_status: got done=%b err=%b words=%0d required 0/0/0", load_done, load_err, words_loaded); else n_pass++;
        errs = 0;
        for (int i = 0; i < 32; i++) begin
            addr = 5'(i);
            #1;
            if (inst !== 32'h0) errs++;
        end
        n_total++; if (errs != 0) $display("FAIL midrst_ram: got %0d nonzero words required 0", errs); else n_pass++;
        a0 = acc_cnt;
        @(negedge clk);
        in_valid = 1'b1;
        in_byte  = 8'h24;
        repeat (4) @(negedge clk);
        n_total++; if (acc_cnt != a0 || in_ready !== 1'b0) $display("FAIL midrst_nostart: got accepted=%0d ready=%b required 0/0", acc_cnt - a0, in_ready); else n_pass++;
        in_valid = 1'b0;
        pulse_start();
        n_total++; if (in_ready !== 1'b1 || busy !== 1'b1) $display("FAIL midrst_restart: got ready=%b busy=%b required 1/1", in_ready, busy); else n_pass++;
    endtask

    initial begin
        n_pass     = 0;
        n_total    = 0;
        acc_cnt    = 0;
        rst        = 1'b1;
        load_start = 1'b0;
        in_valid   = 1'b0;
        in_byte    = 8'h00;
        addr       = 5'd0;
        test_reset();
        test_good_load();
        test_backpressure();
        test_bad_count();
        test_bad_checksum();
        test_full_depth();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
